mccu_fsm: RTL
=============

// Module: mccu_fsm
// PURPOSE
//  Multicycle MIPS control unit: parametrised successor to the single-cycle control decoder.
//  Sequences each instruction through IF/ID/EXE/MEM/WB with one shared memory port.
//  Handshakes with memory via mem_req/mem_rdy, so memory latency may vary.
//  Drives datapath enables and muxes.
//  Supports the same 22 instructions: add sub and or xor sll srl sra jr nor slt,
//  addi andi ori xori lw sw beq bne lui j jal.
// PARAMETERS
//  ALUC_W   4   width of aluc; encoding sits in bits [3:0], upper bits driven 0 (min 4)
//  CNT_W    32  width of performance counters (MCCU_PERF_EN only)
// PORTS
//  clk       in   1       clock, rising edge
//  resetn    in   1       asynchronous active-low reset
//  op        in   6       IR[31:26], valid from ID onward
//  func      in   6       IR[5:0]
//  z         in   1       ALU zero flag, sampled in EXE
//  mem_rdy   in   1       memory completes current access this cycle
//  mem_req   out  1       memory access request (IF, MEM)
//  iord      out  1       0: address=PC, 1: address=ALU result register
//  wir       out  1       load IR with memory data
//  wpc       out  1       write PC
//  pcsource  out  2       00 PC+4, 01 branch target, 10 jr reg, 11 jump addr
//  wreg      out  1       register-file write
//  regrt     out  1       dest = rt (else rd)
//  jal       out  1       dest = r31, data = PC+4
//  m2reg     out  1       write-back data = memory data register
//  wmem      out  1       memory write (qualifies mem_req in MEM)
//  alusrca   out  1       0: PC, 1: rs (shift: sa)
//  alusrcb   out  2       00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
//  shift     out  1       ALU A = sa
//  sext      out  1       sign-extend imm (else zero-extend)
//  aluc      out  ALUC_W  ALU op
//  illegal   out  1       one-cycle pulse on undecodable instruction
//  state     out  3       current state (debug)
// BEHAVIOUR
//  States: RST=0 IF=1 ID=2 EXE=3 MEM=4 WB=5. Reset -> RST; all outputs 0 in RST.
//  RST -> IF unconditionally on the first clock after resetn deasserts.
//  IF: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluc=add.
//   Stays in IF while !mem_rdy. On mem_rdy: wir=1, wpc=1, pcsource=00, -> ID.
//  ID: alusrca=0, alusrcb=11, aluc=add (branch target to ALU reg).
//   j/jal: wpc=1, pcsource=11; jal also wreg=1, jal=1. -> IF.
//   jr: wpc=1, pcsource=10, -> IF. Illegal op/func: illegal=1, no writes, -> IF.
//   Otherwise -> EXE.
//  EXE: R-ALU: alusrca=1, alusrcb=00, -> WB. Shifts: shift=1.
//   I-ALU/lui: alusrcb=10, -> WB. lw/sw: alusrcb=10, sext=1, aluc=add, -> MEM.
//   beq/bne: alusrcb=00, aluc=0010, sext=1;
//   wpc = beq&z | bne&~z, pcsource=01, -> IF.
//  MEM: mem_req=1, iord=1, wmem=sw. Held while !mem_rdy (wmem stays asserted).
//   On mem_rdy: sw -> IF, lw -> WB.
//  WB: wreg=1; regrt for I-type/lw; m2reg for lw. -> IF.
//  All outputs are combinational from state and op/func; no output toggles mid-state
//   except via mem_rdy/z.
//  aluc: add/addi/lw/sw 0000, sub 0100, and/andi 0001, or/ori 0101, xor/xori/beq/bne 0010,
//   sll 0011, srl 0111, sra 1111, slt 1000, nor 1101, lui 0110.
//  sext = addi|lw|sw|beq|bne.
//  Latency, zero-wait memory: j/jal/jr 2 cycles, beq/bne 3, R/I-ALU 4, sw 4, lw 5.
//   Each wait cycle adds 1.
//  Async reset mid-instruction: immediate return to RST; no partial writes persist
//   beyond the reset edge.
// CONFIGURATION
//  MCCU_PERF_EN defined: adds outputs instret[CNT_W] and cycles[CNT_W], both reset to 0.
//   cycles increments every clock outside RST.
//   instret increments on every transition into IF from ID/EXE/MEM/WB, including illegal.
//   Both wrap modulo 2^CNT_W.
//  MCCU_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset: resetn=0 -> state=0, all outputs 0. Release, mem_rdy=1 -> state 0,1,2 on successive clocks.
//  2. add (op=0, func=100000), mem_rdy=1: states IF,ID,EXE,WB.
//     WB: wreg=1, regrt=0, aluc=0000. 4 cycles.
//  3. lw (op=100011), mem_rdy low 3 cycles in MEM: MEM held 4 cycles with iord=1, mem_req=1.
//     Then WB: m2reg=1, wreg=1, regrt=1.
//  4. beq (op=000100): z=1 -> EXE wpc=1, pcsource=01. z=0 -> wpc=0. Both return to IF after 3 cycles.
//  5. jal (op=000011): ID has wpc=1, pcsource=11, wreg=1, jal=1, next state IF. op=111111 -> illegal=1 for 1 cycle, wreg=0, wmem=0.
//  6. MCCU_PERF_EN, CNT_W=4: 16 j instructions -> instret wraps 15->0. resetn pulse mid-EXE -> both counters 0.

Source files
------------

// File: rtl/mccu_fsm.sv
// Multicycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer sharing one memory port.
// Optional MCCU_PERF_EN macro adds retired-instruction and cycle counters.
module mccu_fsm #(
  parameter int ALUC_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic              z,
  input  logic              mem_rdy,
  output logic              mem_req,
  output logic              iord,
  output logic              wir,
  output logic              wpc,
  output logic [1:0]        pcsource,
  output logic              wreg,
  output logic              regrt,
  output logic              jal,
  output logic              m2reg,
  output logic              wmem,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic              shift,
  output logic              sext,
  output logic [ALUC_W-1:0] aluc,
  output logic              illegal,
  output logic [2:0]        state
`ifdef MCCU_PERF_EN
  ,
  output logic [CNT_W-1:0]  instret,
  output logic [CNT_W-1:0]  cycles
`endif
);

  localparam logic [2:0] S_RST = 3'd0;
  localparam logic [2:0] S_IF  = 3'd1;
  localparam logic [2:0] S_ID  = 3'd2;
  localparam logic [2:0] S_EXE = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4;
  localparam logic [2:0] S_WB  = 3'd5;

  if (ALUC_W < 4) begin : g_aluc_w_check
    $error("mccu_fsm: ALUC_W must be at least 4");
  end
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("mccu_fsm: CNT_W must be at least 1");
  end

  logic [2:0] state_reg, state_next;
  logic       r_alu, r_shift, is_jr, i_alu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, legal;
  logic       sext_dec;
  logic [3:0] aluc_dec, aluc_val;

  // Instruction decode; aluc_dec is the ALU op used in EXE for ALU-class instructions.
  always_comb begin
    r_alu = 1'b0; r_shift = 1'b0; is_jr = 1'b0; i_alu = 1'b0;
    is_lw = 1'b0; is_sw = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
    is_j = 1'b0; is_jal = 1'b0; legal = 1'b1; aluc_dec = 4'b0000;
    case (op)
      6'b000000: begin
        case (func)
          6'b100000: begin r_alu = 1'b1; aluc_dec = 4'b0000; end
          6'b100010: begin r_alu = 1'b1; aluc_dec = 4'b0100; end
          6'b100100: begin r_alu = 1'b1; aluc_dec = 4'b0001; end
          6'b100101: begin r_alu = 1'b1; aluc_dec = 4'b0101; end
          6'b100110: begin r_alu = 1'b1; aluc_dec = 4'b0010; end
          6'b100111: begin r_alu = 1'b1; aluc_dec = 4'b1101; end
          6'b101010: begin r_alu = 1'b1; aluc_dec = 4'b1000; end
          6'b000000: begin r_alu = 1'b1; r_shift = 1'b1; aluc_dec = 4'b0011; end
          6'b000010: begin r_alu = 1'b1; r_shift = 1'b1; aluc_dec = 4'b0111; end
          6'b000011: begin r_alu = 1'b1; r_shift = 1'b1; aluc_dec = 4'b1111; end
          6'b001000: is_jr = 1'b1;
          default:   legal = 1'b0;
        endcase
      end
      6'b001000: begin i_alu = 1'b1; aluc_dec = 4'b0000; end
      6'b001100: begin i_alu = 1'b1; aluc_dec = 4'b0001; end
      6'b001101: begin i_alu = 1'b1; aluc_dec = 4'b0101; end
      6'b001110: begin i_alu = 1'b1; aluc_dec = 4'b0010; end
      6'b001111: begin i_alu = 1'b1; aluc_dec = 4'b0110; end
      6'b100011: is_lw  = 1'b1;
      6'b101011: is_sw  = 1'b1;
      6'b000100: is_beq = 1'b1;
      6'b000101: is_bne = 1'b1;
      6'b000010: is_j   = 1'b1;
      6'b000011: is_jal = 1'b1;
      default:   legal  = 1'b0;
    endcase
  end

  assign sext_dec = (op == 6'b001000) | is_lw | is_sw | is_beq | is_bne;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_RST;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = S_RST;
    case (state_reg)
      S_RST: state_next = S_IF;
      S_IF:  state_next = mem_rdy ? S_ID : S_IF;
      S_ID:  state_next = (!legal || is_j || is_jal || is_jr) ? S_IF : S_EXE;
      S_EXE: state_next = (is_lw || is_sw) ? S_MEM : ((is_beq || is_bne) ? S_IF : S_WB);
      S_MEM: state_next = !mem_rdy ? S_MEM : (is_sw ? S_IF : S_WB);
      S_WB:  state_next = S_IF;
      default: state_next = S_RST;
    endcase
  end

  // Moore outputs from state and decoded instruction; only mem_rdy/z act within a state.
  always_comb begin
    mem_req = 1'b0; iord = 1'b0; wir = 1'b0; wpc = 1'b0; pcsource = 2'b00;
    wreg = 1'b0; regrt = 1'b0; jal = 1'b0; m2reg = 1'b0; wmem = 1'b0;
    alusrca = 1'b0; alusrcb = 2'b00; shift = 1'b0; sext = 1'b0;
    aluc_val = 4'b0000; illegal = 1'b0;
    case (state_reg)
      S_IF: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        wir     = mem_rdy;
        wpc     = mem_rdy;
      end
      S_ID: begin
        alusrcb = 2'b11;
        sext    = sext_dec;
        if (!legal) begin
          illegal = 1'b1;
        end else if (is_j || is_jal) begin
          wpc = 1'b1; pcsource = 2'b11; wreg = is_jal; jal = is_jal;
        end else if (is_jr) begin
          wpc = 1'b1; pcsource = 2'b10;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        if (is_lw || is_sw) begin
          alusrcb = 2'b10; sext = 1'b1; aluc_val = 4'b0000;
        end else if (is_beq || is_bne) begin
          alusrcb = 2'b00; aluc_val = 4'b0010; sext = 1'b1; pcsource = 2'b01;
          wpc = (is_beq & z) | (is_bne & ~z);
        end else if (r_alu) begin
          alusrcb = 2'b00; shift = r_shift; aluc_val = aluc_dec;
        end else begin
          alusrcb = 2'b10; sext = sext_dec; aluc_val = aluc_dec;
        end
      end
      S_MEM: begin
        mem_req = 1'b1; iord = 1'b1; wmem = is_sw;
      end
      S_WB: begin
        wreg = 1'b1; regrt = i_alu | is_lw; m2reg = is_lw;
      end
      default: ;
    endcase
  end

  assign aluc  = ALUC_W'(aluc_val);
  assign state = state_reg;

`ifdef MCCU_PERF_EN
  logic [CNT_W-1:0] instret_reg, cycles_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      instret_reg <= '0;
      cycles_reg  <= '0;
    end else begin
      if (state_reg != S_RST) cycles_reg <= cycles_reg + CNT_W'(1);
      if (state_next == S_IF && state_reg >= S_ID && state_reg <= S_WB)
        instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  assign instret = instret_reg;
  assign cycles  = cycles_reg;
`endif

endmodule
